// File: rtl/regfile_dump_reader.sv
// -----------------------------------------------------------------------------
// regfile_dump_reader
//
// Debug read-out engine for the MIPS core's general-purpose register file.
// A start pulse walks the register file's combinational read port through
// registers 0..NUM_REGS-1. Each word is captured and then streamed to a
// debug/trace sink over a valid/ready interface. The block shares the read
// port with the core, so it may only be used while the core is stalled or
// halted.
//
// Optional feature macro: DUMP_CHECKSUM_EN
//   defined   : an extra final beat carries the XOR of all dumped words
//               (out_sum=1, out_idx=0, out_last=1).
//   undefined : no checksum beat; out_sum is tied low and out_last marks
//               register NUM_REGS-1.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   one-cycle dump request, ignored while busy
//   rd_adr     out  register file read address (always the current index)
//   rd_data    in   combinational register file read data for rd_adr
//   out_valid  out  stream word valid
//   out_ready  in   sink accepts word
//   out_data   out  register value, or checksum on the checksum beat
//   out_idx    out  register index of out_data (0 on the checksum beat)
//   out_sum    out  high on the checksum beat
//   out_last   out  high on the final beat of the dump
//   busy       out  dump in progress (LOAD through DONE)
//   done       out  one-cycle pulse after the final beat is accepted
//   dbg_state  out  current FSM state encoding, for debug and checkers
//
// Handshake: a beat transfers on a rising edge where out_valid && out_ready.
// Once out_valid rises, out_data/out_idx/out_sum/out_last stay stable until
// that transfer. out_valid never depends combinationally on out_ready, and
// out_ready has no effect while out_valid is low.
// -----------------------------------------------------------------------------
module regfile_dump_reader #(
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [ADDR_W-1:0] rd_adr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_idx,
   output logic              out_sum,
   output logic              out_last,
   output logic              busy,
   output logic              done,
   output logic [2:0]        dbg_state
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_SEND = 3'd2,
`ifdef DUMP_CHECKSUM_EN
      S_SUM  = 3'd3,
`endif
      S_DONE = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;       // register currently addressed
   logic [DATA_W-1:0] data_q, data_d;     // word captured at the LOAD edge
   logic [ADDR_W-1:0] oidx_q, oidx_d;     // index belonging to data_q

`ifdef DUMP_CHECKSUM_EN
   logic [DATA_W-1:0] sum_q, sum_d;       // running XOR of captured words
`endif

   // ---------------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         data_q  <= '0;
         oidx_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         oidx_q  <= oidx_d;
      end
   end

`ifdef DUMP_CHECKSUM_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end
`endif

   // ---------------------------------------------------------------------------
   // Next-state and datapath update
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      data_d  = data_q;
      oidx_d  = oidx_q;
`ifdef DUMP_CHECKSUM_EN
      sum_d   = sum_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (start) begin
               idx_d   = '0;
`ifdef DUMP_CHECKSUM_EN
               sum_d   = '0;
`endif
               state_d = S_LOAD;
            end
         end

         // rd_adr already shows idx_q this cycle, so rd_data is the word to
         // capture. Its value reflects the register contents at this edge.
         S_LOAD: begin
            data_d  = rd_data;
            oidx_d  = idx_q;
`ifdef DUMP_CHECKSUM_EN
            sum_d   = sum_q ^ rd_data;
`endif
            state_d = S_SEND;
         end

         S_SEND: begin
            if (out_ready) begin
               if (idx_q == LAST_IDX) begin
`ifdef DUMP_CHECKSUM_EN
                  state_d = S_SUM;
`else
                  state_d = S_DONE;
`endif
               end else begin
                  idx_d   = idx_q + ADDR_W'(1);
                  state_d = S_LOAD;
               end
            end
         end

`ifdef DUMP_CHECKSUM_EN
         S_SUM: begin
            if (out_ready) begin
               state_d = S_DONE;
            end
         end
`endif

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Outputs: decoded from registered state only
   // ---------------------------------------------------------------------------
   always_comb begin
      rd_adr    = idx_q;
      out_valid = 1'b0;
      out_data  = data_q;
      out_idx   = oidx_q;
      out_sum   = 1'b0;
      out_last  = 1'b0;
      busy      = (state_q != S_IDLE);
      done      = (state_q == S_DONE);
      dbg_state = state_q;

      case (state_q)
         S_SEND: begin
            out_valid = 1'b1;
`ifndef DUMP_CHECKSUM_EN
            out_last  = (oidx_q == LAST_IDX);
`endif
         end
`ifdef DUMP_CHECKSUM_EN
         S_SUM: begin
            out_valid = 1'b1;
            out_data  = sum_q;
            out_idx   = '0;
            out_sum   = 1'b1;
            out_last  = 1'b1;
         end
`endif
         default: begin
            out_valid = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// -----------------------------------------------------------------------------
// tb_regfile_dump_reader
//
// Bench for regfile_dump_reader. It holds a register file array that feeds
// rd_data combinationally from rd_adr. At each start pulse it builds the full
// list of beats the dump must produce, read from that array. A single
// negedge compare process checks every valid beat, the done pulse, busy, and
// the cycle timing against that list. Build with +define+DUMP_CHECKSUM_EN to
// expect the checksum beat.
// -----------------------------------------------------------------------------
module tb_regfile_dump_reader;

   localparam int NUM_REGS = 32;
   localparam int ADDR_W   = 5;
   localparam int DATA_W   = 32;
`ifdef DUMP_CHECKSUM_EN
   localparam int CSUM = 1;
`else
   localparam int CSUM = 0;
`endif
   localparam int NBEATS = NUM_REGS + CSUM;
   localparam int BW     = 2 + ADDR_W + DATA_W;   // {sum, last, idx, data}

   // ---------------------------------------------------------------------------
   // Clock / reset / DUT
   // ---------------------------------------------------------------------------
   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic [ADDR_W-1:0] rd_adr;
   logic [DATA_W-1:0] rd_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [ADDR_W-1:0] out_idx;
   logic              out_sum;
   logic              out_last;
   logic              busy;
   logic              done;
   logic [2:0]        dbg_state;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   logic [DATA_W-1:0] mem [NUM_REGS];
   assign rd_data = (rd_adr == '0) ? '0 : mem[rd_adr];

   regfile_dump_reader #(
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .rd_adr    (rd_adr),
      .rd_data   (rd_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_sum   (out_sum),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done),
      .dbg_state (dbg_state)
   );

   // ---------------------------------------------------------------------------
   // Scoreboard state
   // ---------------------------------------------------------------------------
   int checks = 0;
   int errors = 0;

   logic [BW-1:0]     exp_q[$];
   logic [DATA_W-1:0] model_xor;
   logic [DATA_W-1:0] got_data [NUM_REGS];
   logic [DATA_W-1:0] got_sum;
   int                accepted;
   int                dones;
   bit                done_seen;
   bit                prev_done;
   bit                timing_on;
   int                start_cyc;
   int                ready_mode;   // 0: always ready, 1: random with stalls
   int                stall_cnt;
   bit                stalled_first;
   bit                stalled_last;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected beat list for one dump, taken from the register file contents.
   task automatic build_dump();
      logic [DATA_W-1:0] w;
      logic [DATA_W-1:0] x;
      x = '0;
      exp_q.delete();
      for (int i = 0; i < NUM_REGS; i++) begin
         w = (i == 0) ? '0 : mem[i];
         x ^= w;
         exp_q.push_back({1'b0, (CSUM == 0) && (i == NUM_REGS - 1), ADDR_W'(i), w});
      end
      if (CSUM != 0) exp_q.push_back({1'b1, 1'b1, {ADDR_W{1'b0}}, x});
      model_xor = x;
   endtask

   task automatic load_pattern();
      for (int i = 0; i < NUM_REGS; i++) mem[i] = DATA_W'(i) * 32'h0101_0101;
   endtask

   // ---------------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------------
   task automatic do_start();
      @(posedge clk);
      #1;
      build_dump();
      accepted      = 0;
      dones         = 0;
      done_seen     = 1'b0;
      stalled_first = 1'b0;
      stalled_last  = 1'b0;
      got_sum       = 'x;
      for (int i = 0; i < NUM_REGS; i++) got_data[i] = 'x;
      start_cyc     = cyc;
      start         = 1'b1;
      @(posedge clk);
      #1;
      start         = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!done_seen && n < 4000) begin
         @(posedge clk);
         n++;
      end
      if (!done_seen) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no done pulse within %0d cycles", n);
      end
      repeat (2) @(posedge clk);
   endtask

   task automatic wait_rel(input int rel);
      while (cyc - start_cyc < rel) @(posedge clk);
   endtask

   task automatic run_dump();
      do_start();
      wait_done();
      check("dones_per_dump", dones, 1);
      check("accepted_beats", accepted, NBEATS);
   endtask

   // out_ready driver. Mode 1 forces a 10-cycle low stretch the first time
   // register 0 and the last register are offered, and is random elsewhere.
   always @(posedge clk) begin
      #1;
      if (stall_cnt > 0) begin
         out_ready = 1'b0;
         stall_cnt--;
      end else if (ready_mode == 0) begin
         out_ready = 1'b1;
      end else if (out_valid && !out_sum && out_idx == '0 && !stalled_first) begin
         stalled_first = 1'b1;
         out_ready     = 1'b0;
         stall_cnt     = 9;
      end else if (out_valid && !out_sum && out_idx == ADDR_W'(NUM_REGS - 1) && !stalled_last) begin
         stalled_last = 1'b1;
         out_ready    = 1'b0;
         stall_cnt    = 9;
      end else begin
         out_ready = 1'($urandom_range(0, 1));
      end
   end

   // ---------------------------------------------------------------------------
   // Compare process
   // ---------------------------------------------------------------------------
   always @(negedge clk) begin
      int rel;
      int exp_rel;
      rel = cyc - start_cyc;
      if (!rst_n) begin
         check("outputs_in_reset",
               {out_valid, out_sum, out_last, busy, done, out_idx, rd_adr, out_data}, '0);
         prev_done = 1'b0;
      end else begin
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_beat: got idx %0d data 0x%0h, expected no beat",
                        out_idx, out_data);
            end else begin
               check("beat", {out_sum, out_last, out_idx, out_data}, exp_q[0]);
               if (timing_on) begin
                  exp_rel = out_sum ? 2 * NUM_REGS + 1 : 2 + 2 * accepted;
                  check("beat_cycle", rel, exp_rel);
               end
               if (out_ready) begin
                  if (out_sum) got_sum = out_data;
                  else         got_data[out_idx] = out_data;
                  void'(exp_q.pop_front());
                  accepted++;
               end
            end
         end
         if (done) begin
            check("done_queue_empty", exp_q.size(), 0);
            check("busy_at_done", busy, 1);
            if (timing_on) check("done_cycle", rel, 2 * NUM_REGS + 1 + CSUM);
            dones++;
            done_seen = 1'b1;
         end
         if (prev_done) check("idle_after_done", {busy, out_valid}, 0);
         if (exp_q.size() > 0 && rel >= 1) check("busy_during_dump", busy, 1);
         prev_done = done;
      end
   end

   // ---------------------------------------------------------------------------
   // Directed sequence
   // ---------------------------------------------------------------------------
   initial begin
      rst_n      = 1'b0;
      start      = 1'b0;
      out_ready  = 1'b0;
      ready_mode = 0;
      stall_cnt  = 0;
      timing_on  = 1'b0;
      start_cyc  = 0;
      prev_done  = 1'b0;
      load_pattern();

      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      @(negedge clk);
      check("idle_after_reset", {busy, done, out_valid, rd_adr, dbg_state}, 0);

      // Pattern dump, sink always ready: exact timing and hand-computed words.
      ready_mode = 0;
      timing_on  = 1'b1;
      run_dump();
      check("pattern_r0", got_data[0], 32'h0000_0000);
      check("pattern_r7", got_data[7], 32'h0707_0707);
      check("pattern_r31", got_data[31], 32'h1F1F_1F1F);
      check("pattern_model_xor", model_xor, 32'h0000_0000);
`ifdef DUMP_CHECKSUM_EN
      check("pattern_checksum", got_sum, 32'h0000_0000);
`endif

      // Random contents, random back-pressure with long stalls.
      for (int i = 0; i < NUM_REGS; i++) mem[i] = $urandom;
      ready_mode = 1;
      timing_on  = 1'b0;
      run_dump();
      check("random_r1", got_data[1], mem[1]);
`ifdef DUMP_CHECKSUM_EN
      check("random_checksum", got_sum, model_xor);
`endif

      // start re-pulsed in cycles 5 and 40 must be ignored.
      load_pattern();
      ready_mode = 0;
      timing_on  = 1'b1;
      do_start();
      wait_rel(5);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_rel(40);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done();
      check("restart_ignored_dones", dones, 1);
      check("restart_ignored_beats", accepted, NBEATS);

      // Reset asserted in cycle 20 aborts at once; no done follows.
      do_start();
      wait_rel(20);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_outputs",
            {out_valid, out_sum, out_last, busy, done, out_idx, rd_adr, out_data}, '0);
      exp_q.delete();
      timing_on = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (4) @(posedge clk);
      check("no_done_after_abort", dones, 0);
      timing_on = 1'b1;
      run_dump();
      check("post_abort_r3", got_data[3], 32'h0303_0303);

      // r5 rewritten after its LOAD: old value now, new value next dump.
      load_pattern();
      do_start();
      wait_rel(20);
      mem[5] = 32'hDEAD_BEEF;
      wait_done();
      check("wb_first_dump_r5", got_data[5], 32'h0505_0505);
      run_dump();
      check("wb_second_dump_r5", got_data[5], 32'hDEAD_BEEF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/regfile_dump_reader.md
# regfile_dump_reader

Debug read-out engine for the single-cycle MIPS core's 32 x 32-bit general-purpose register file. On a start pulse it drives the register file's combinational read-address port through registers 0..NUM_REGS-1, captures each read word, and streams it out over a valid/ready interface to the debug/trace sink. It is the reader counterpart to the datapath's write-back port, and shares a read port with the core. It is used only while the core is stalled or halted.

## Interface
- NUM_REGS, 32, number of registers dumped, starting at index 0 (2..32)
- ADDR_W, 5, register address width
- DATA_W, 32, register word width
- clk  input  1  system clock, rising-edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to begin a dump; ignored while busy
- rd_adr  output  ADDR_W  read address to register file
- rd_data  input  DATA_W  combinational read data from register file for rd_adr
- out_valid  output  1  stream word valid
- out_ready  input  1  sink accepts word
- out_data  output  DATA_W  register value, or checksum on checksum beat
- out_idx  output  ADDR_W  register index of out_data; 0 on checksum beat
- out_sum  output  1  high on checksum beat; constant 0 when checksum disabled
- out_last  output  1  high on final beat of the dump
- busy  output  1  dump in progress
- done  output  1  one-cycle pulse after final beat accepted

## Operation
- Clock is clk. Reset is rst_n: asynchronous assert, active-low.
- States: IDLE, LOAD, SEND, SUM (checksum build only), DONE.
- IDLE: busy=0. start=1 -> idx<=0, checksum<=0, go LOAD.
- LOAD: rd_adr=idx. At the clock edge: out_data<=rd_data, out_idx<=idx, checksum<=checksum^rd_data. Go to SEND.
- SEND: out_valid=1; outputs held stable until out_valid&&out_ready.
  - On handshake with idx<NUM_REGS-1: idx<=idx+1, go LOAD.
  - On handshake with idx==NUM_REGS-1: go SUM if checksum is enabled, else go DONE.
- SUM: out_valid=1, out_data=checksum, out_sum=1, out_idx=0, out_last=1. On handshake, go DONE.
- DONE: done=1 for one cycle, busy still 1. Next state IDLE.
- out_last rules:
  - Without checksum, out_last=1 only on the idx==NUM_REGS-1 beat.
  - With checksum, out_last=1 only on the SUM beat.
- rd_adr always equals registered idx. It is held during SEND/SUM/DONE and is 0 in IDLE after reset.
- The dump is not an atomic snapshot. Each word reflects register contents at its LOAD edge. Register 0 always reads 0, per register file rules.
- start while busy: ignored, with no restart or queueing.
- out_ready high outside SEND/SUM: no effect.
- Checksum arithmetic: DATA_W-bit bitwise XOR of all captured words, no carry.

## Timing
- Reset values: rd_adr=0, out_valid=0, out_data=0, out_idx=0, out_sum=0, out_last=0, busy=0, done=0, state IDLE.
- Reset mid-dump aborts immediately and asynchronously: out_valid drops, state returns to IDLE, no done pulse.
- start sampled in cycle 0 -> LOAD in cycle 1 (rd_adr=0) -> out_valid in cycle 2.
- With out_ready held high: 2 cycles per word.
  - Word k valid in cycle 2+2k.
  - Without checksum: last word (k=31) valid in cycle 64, done in cycle 65, busy=0 from cycle 66.
  - With checksum: SUM valid in cycle 65, done in cycle 66, busy=0 from cycle 67.
- out_ready low stalls indefinitely. Each stall cycle adds one cycle; no word is dropped or duplicated.
- busy is high from cycle 1 through the DONE cycle inclusive.
- A new start is accepted in the first IDLE cycle after DONE.

## Configuration
- DUMP_CHECKSUM_EN defined: SUM state and checksum register are present. The dump is NUM_REGS+1 beats, and the last beat carries the XOR of all words with out_sum=1.
- Not defined: no SUM state and no checksum register. The dump is NUM_REGS beats, out_sum is tied 0, and out_last is on index NUM_REGS-1.

## Test plan
- Register file preloaded with mem[i]=i*0x01010101 (mem[0]=0), start pulse, out_ready=1 -> 32 beats, out_idx 0..31 in order, data matches, out_last only on idx 31, done in cycle 65.
- Same preload with DUMP_CHECKSUM_EN -> 33rd beat with out_sum=1, out_last=1, out_data equal to the XOR of all words (0x00000000 for this pattern since i*0x01010101 XOR over 0..31 cancels; also check against the bench-computed XOR for a random preload), done in cycle 66.
- out_ready toggled randomly, including 10-cycle low stretches on idx 0 and 31 -> out_data/out_idx stable while stalled, exactly 32 (33) accepted beats, no duplicates.
- start re-pulsed in cycles 5 and 40 during a dump -> ignored; single dump, single done pulse.
- rst_n asserted in cycle 20 mid-dump -> all outputs 0 asynchronously, no done. start after release -> clean dump from idx 0.
- Write-back to r5 between its LOAD and the next dump -> first dump shows old value, second dump shows new value.
